regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
Write-side controller for the 32x32 register file; it alone drives the file's single write port (D, D_Addr, D_En). It merges in-order single-cycle ALU results with out-of-order-arriving, in-order-returning long-latency load results, buffering loads in a DEPTH-entry queue. It also keeps a busy scoreboard so decode stalls on any register with a pending load.

Parameters:
DEPTH, 4, pending-load queue entries (power of 2, 2..16)
AW, 2, log2(DEPTH) pointer width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
wb_valid  in  1  ALU result valid this cycle
wb_addr  in  5  ALU destination register
wb_data  in  32  ALU result
ld_issue  in  1  load issued; allocate queue entry
ld_addr  in  5  load destination register
ld_ready  out  1  queue can accept ld_issue (count < DEPTH)
ld_ret_valid  in  1  load data returning, oldest-issued first
ld_ret_data  in  32  returned load data
S_Addr  in  5  decode source-S query
T_Addr  in  5  decode source-T query
dest_addr  in  5  decode destination query
stall  out  1  any queried register busy
D  out  32  register-file write data (registered)
D_Addr  out  5  register-file write address (registered)
D_En  out  1  register-file write enable (registered)
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=0 at posedge): D=0, D_Addr=0, D_En=0, err=0, queue empty, all pointers/count 0. Reset mid-operation discards all pending entries and in-flight returns.
- Queue entry: {addr[4:0], data[31:0], has_data}. Three pointers: alloc (tail), fill (oldest entry lacking data), head (drain).
- Allocate: ld_issue && ld_ready -> write ld_addr at tail, has_data=0, count+1. ld_issue while !ld_ready -> ignored, err<=1.
- Fill: ld_ret_valid with an allocated entry lacking data -> store ld_ret_data at fill pointer, has_data<=1, advance fill. ld_ret_valid with no such entry -> ignored, err<=1.
- Arbitration, evaluated each cycle, result registered:
  - wb_valid=1 -> ALU wins: next D/D_Addr = wb_data/wb_addr. ALU is never stalled.
  - else if head entry valid and has_data=1 -> drain: next D/D_Addr = head data/addr; head advances; count-1.
  - else next D_En=0 (D/D_Addr hold).
- Register 0: any write whose address is 0 yields next D_En=0 but still consumes the slot/entry. Loads to r0 allocate normally and never set busy.
- Latency: ALU wb_valid in cycle N -> D_En=1 in N+1. Load return in N -> earliest D_En in N+2 (data visible to arbitration only after the fill edge).
- Simultaneous events:
  - Allocate and drain in one cycle are both legal. ld_ready uses the pre-edge count, so full+drain does not admit a push that cycle.
  - Fill and drain of the same entry in one cycle: not possible; drain sees has_data only from the following cycle.
- Scoreboard: busy(r) = r!=0 and some valid entry has addr==r (DEPTH comparators, combinational).
  - stall = busy(S_Addr) | busy(T_Addr) | busy(dest_addr).
  - An entry leaves the queue at the edge its write is loaded into D/D_En. In the cycle D_En=1 for it, busy is already clear and the register file's write-to-read forwarding supplies the value. Stall therefore drops exactly in that cycle.
- Count width AW+1; pointers wrap modulo DEPTH.
- err is cleared only by reset.

Test Plan:
- Reset: hold rst=0 two cycles with wb_valid=1 -> D_En=0, D=0, ld_ready=1, err=0, stall=0.
- ALU path: wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF in cycle N -> cycle N+1: D_En=1, D_Addr=5, D=0xDEADBEEF. Same stimulus with wb_addr=0 -> D_En=0.
- Load + stall: ld_issue addr=9; S_Addr=9 -> stall=1. ld_ret_data=0x1234 three cycles later (cycle N) -> cycle N+2: D_En=1, D_Addr=9, D=0x1234, stall=0 that cycle.
- Collision: load data queued and wb_valid=1 (addr 3, 0xA) for two cycles -> D_En carries ALU writes for two cycles, load write follows in the third cycle; order preserved.
- Full/overflow: issue 4 loads (addrs 1-4) -> ld_ready=0. 5th ld_issue -> ignored, err=1. Return 4 data words -> writes to 1,2,3,4 in order; ld_ready returns to 1 after the first drain.
- Spurious return / mid-op reset: ld_ret_valid with empty queue -> err=1, no D_En. Two pending loads then rst=0 -> queue empty, stall=0, err=0, no later D_En.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// ---------------
// Write-side controller for the 32x32 register file. It owns the file's
// single write port (D, D_Addr, D_En). Single-cycle ALU results always win
// that port. Long-latency loads are held in a DEPTH-entry in-order queue
// until their data has returned, and then drain in issue order. A busy
// scoreboard stalls decode on any register that still has a load pending.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   wb_valid/addr/data       ALU result (never stalled)
//   ld_issue/ld_addr         allocate a queue entry for a new load
//   ld_ready                 queue has room (count < DEPTH)
//   ld_ret_valid/data        load data, oldest outstanding load first
//   S_Addr/T_Addr/dest_addr  decode register queries
//   stall                    any queried register has a pending load
//   D/D_Addr/D_En            registered register-file write port
//   err                      sticky protocol error (overflow / spurious return)
module regfile_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_addr,
  output logic        ld_ready,
  input  logic        ld_ret_valid,
  input  logic [31:0] ld_ret_data,
  input  logic [4:0]  S_Addr,
  input  logic [4:0]  T_Addr,
  input  logic [4:0]  dest_addr,
  output logic        stall,
  output logic [31:0] D,
  output logic [4:0]  D_Addr,
  output logic        D_En,
  output logic        err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [DEPTH-1:0] q_has;
  logic [AW-1:0]    alloc_ptr;
  logic [AW-1:0]    fill_ptr;
  logic [AW-1:0]    head_ptr;
  logic [AW:0]      count;

  logic             do_alloc;
  logic             fill_ok;
  logic             do_fill;
  logic             do_drain;
  logic [DEPTH-1:0] hit;
  logic             nxt_en;
  logic [31:0]      nxt_d;
  logic [4:0]       nxt_a;

  // Queue control decisions, all taken from pre-edge state.
  always_comb begin
    ld_ready = (count < DEPTH_C);
    do_alloc = ld_issue & ld_ready;
    // The fill pointer rests on the alloc slot once every entry has data,
    // so "valid and still lacking data" tells us whether a return is expected.
    fill_ok  = q_vld[fill_ptr] & ~q_has[fill_ptr];
    do_fill  = ld_ret_valid & fill_ok;
    // has_data is only seen here the cycle after the fill edge.
    do_drain = ~wb_valid & q_vld[head_ptr] & q_has[head_ptr];
  end

  // Busy scoreboard: one comparator per entry; r0 entries never count.
  always_comb begin
    hit = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = q_vld[i] & (q_addr[i] != 5'd0) &
               ((q_addr[i] == S_Addr) | (q_addr[i] == T_Addr) |
                (q_addr[i] == dest_addr));
    end
    stall = |hit;
  end

  // Write-port arbitration: ALU first, then a ready head entry, else idle.
  always_comb begin
    nxt_en = 1'b0;
    nxt_d  = D;
    nxt_a  = D_Addr;
    if (wb_valid) begin
      nxt_en = (wb_addr != 5'd0);
      nxt_d  = wb_data;
      nxt_a  = wb_addr;
    end else if (do_drain) begin
      nxt_en = (q_addr[head_ptr] != 5'd0);
      nxt_d  = q_data[head_ptr];
      nxt_a  = q_addr[head_ptr];
    end else begin
      nxt_en = 1'b0;
    end
  end

  // Queue storage, pointers, count, write port and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= 5'd0;
        q_data[i] <= 32'd0;
      end
      q_vld     <= {DEPTH{1'b0}};
      q_has     <= {DEPTH{1'b0}};
      alloc_ptr <= {AW{1'b0}};
      fill_ptr  <= {AW{1'b0}};
      head_ptr  <= {AW{1'b0}};
      count     <= {(AW+1){1'b0}};
      D         <= 32'd0;
      D_Addr    <= 5'd0;
      D_En      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Alloc, fill and drain always touch distinct entries: alloc needs an
      // invalid slot, fill a valid slot without data, drain one with data.
      if (do_alloc) begin
        q_addr[alloc_ptr] <= ld_addr;
        q_vld[alloc_ptr]  <= 1'b1;
        q_has[alloc_ptr]  <= 1'b0;
        alloc_ptr         <= alloc_ptr + 1'b1;
      end
      if (do_fill) begin
        q_data[fill_ptr] <= ld_ret_data;
        q_has[fill_ptr]  <= 1'b1;
        fill_ptr         <= fill_ptr + 1'b1;
      end
      if (do_drain) begin
        q_vld[head_ptr] <= 1'b0;
        q_has[head_ptr] <= 1'b0;
        head_ptr        <= head_ptr + 1'b1;
      end
      count  <= count + (AW+1)'(do_alloc) - (AW+1)'(do_drain);
      D      <= nxt_d;
      D_Addr <= nxt_a;
      D_En   <= nxt_en;
      err    <= err | (ld_issue & ~ld_ready) | (ld_ret_valid & ~fill_ok);
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl. A queue-of-structs reference
// model tracks pending loads and the expected registered write port.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst, wb_valid, ld_issue, ld_ret_valid;
  logic [4:0]  wb_addr, ld_addr, S_Addr, T_Addr, dest_addr;
  logic [31:0] wb_data, ld_ret_data;
  logic        ld_ready, stall, D_En, err;
  logic [31:0] D;
  logic [4:0]  D_Addr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          h;
  } ent_t;
  ent_t mq[$];

  logic        exp_en, exp_err;
  logic [31:0] exp_d;
  logic [4:0]  exp_a;

  regfile_wb_ctrl #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .ld_ret_valid(ld_ret_valid), .ld_ret_data(ld_ret_data),
    .S_Addr(S_Addr), .T_Addr(T_Addr), .dest_addr(dest_addr),
    .stall(stall), .D(D), .D_Addr(D_Addr), .D_En(D_En), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_stall();
    return m_busy(S_Addr) | m_busy(T_Addr) | m_busy(dest_addr);
  endfunction

  function automatic logic m_ready();
    return (mq.size() < 4);
  endfunction

  task automatic idle();
    rst = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    ld_issue = 1'b0; ld_addr = 5'd0; ld_ret_valid = 1'b0; ld_ret_data = 32'd0;
    S_Addr = 5'd0; T_Addr = 5'd0; dest_addr = 5'd0;
  endtask

  // Advance the reference model by one clock using the current inputs, then
  // step the DUT and settle just after the edge.
  task automatic cycle();
    int fi;
    bit drain, ready;
    if (!rst) begin
      mq.delete();
      exp_en = 1'b0; exp_d = 32'd0; exp_a = 5'd0; exp_err = 1'b0;
    end else begin
      ready = (mq.size() < 4);
      fi = -1;
      for (int i = 0; i < mq.size(); i++) if (!mq[i].h && fi < 0) fi = i;
      drain = !wb_valid && mq.size() > 0 && mq[0].h;
      if (ld_issue && !ready) exp_err = 1'b1;
      if (ld_ret_valid && fi < 0) exp_err = 1'b1;
      if (wb_valid) begin
        exp_en = (wb_addr != 5'd0); exp_d = wb_data; exp_a = wb_addr;
      end else if (drain) begin
        exp_en = (mq[0].a != 5'd0); exp_d = mq[0].d; exp_a = mq[0].a;
      end else begin
        exp_en = 1'b0;
      end
      if (ld_ret_valid && fi >= 0) begin
        mq[fi].d = ld_ret_data;
        mq[fi].h = 1'b1;
      end
      if (drain) void'(mq.pop_front());
      if (ld_issue && ready) mq.push_back('{a: ld_addr, d: 32'd0, h: 1'b0});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0; wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1111_2222; S_Addr = 5'd5;
    cycle();
    cycle();
    checks++; if (D_En !== 1'b0) begin errors++; $display("FAIL reset_den: got %b want 0", D_En); end
    checks++; if (D !== 32'd0) begin errors++; $display("FAIL reset_d: got %h want 0", D); end
    checks++; if (D_Addr !== 5'd0) begin errors++; $display("FAIL reset_daddr: got %0d want 0", D_Addr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ld_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    idle();
  endtask

  task automatic test_alu();
    idle();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    cycle();
    checks++; if (D_En !== 1'b1) begin errors++; $display("FAIL alu_den: got %b want 1", D_En); end
    checks++; if (D_Addr !== 5'd5) begin errors++; $display("FAIL alu_daddr: got %0d want 5", D_Addr); end
    checks++; if (D !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_d: got %h want deadbeef", D); end
    wb_addr = 5'd0;
    cycle();
    checks++; if (D_En !== 1'b0) begin errors++; $display("FAIL alu_r0_den: got %b want 0", D_En); end
    idle();
    cycle();
  endtask

  task automatic test_load_stall();
    idle();
    ld_issue = 1'b1; ld_addr = 5'd9;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready_issue: got %b want 1", ld_ready); end
    cycle();
    ld_issue = 1'b0; S_Addr = 5'd9;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_stall_pending: got %b want 1", stall); end
    cycle();
    cycle();
    ld_ret_valid = 1'b1; ld_ret_data = 32'h0000_1234;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_stall_ret: got %b want 1", stall); end
    cycle();
    ld_ret_valid = 1'b0;
    #1;
    checks++; if (D_En !== 1'b0) begin errors++; $display("FAIL ld_den_n1: got %b want 0", D_En); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_stall_n1: got %b want 1", stall); end
    cycle();
    checks++; if (D_En !== 1'b1) begin errors++; $display("FAIL ld_den_n2: got %b want 1", D_En); end
    checks++; if (D_Addr !== 5'd9) begin errors++; $display("FAIL ld_daddr_n2: got %0d want 9", D_Addr); end
    checks++; if (D !== 32'h0000_1234) begin errors++; $display("FAIL ld_d_n2: got %h want 00001234", D); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_stall_n2: got %b want 0", stall); end
    idle();
    cycle();
  endtask

  task automatic test_collision();
    idle();
    ld_issue = 1'b1; ld_addr = 5'd7;
    cycle();
    ld_issue = 1'b0; ld_ret_valid = 1'b1; ld_ret_data = 32'h0000_0055;
    cycle();
    ld_ret_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_000A;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++; if (D_En !== 1'b1 || D_Addr !== 5'd3 || D !== 32'h0000_000A) begin
        errors++; $display("FAIL coll_alu%0d: got en=%b a=%0d d=%h want en=1 a=3 d=0000000a", k, D_En, D_Addr, D);
      end
    end
    wb_valid = 1'b0;
    cycle();
    checks++; if (D_En !== 1'b1 || D_Addr !== 5'd7 || D !== 32'h0000_0055) begin
      errors++; $display("FAIL coll_load: got en=%b a=%0d d=%h want en=1 a=7 d=00000055", D_En, D_Addr, D);
    end
    idle();
    cycle();
  endtask

  task automatic test_full();
    logic [4:0]  got_a[$];
    logic [31:0] got_d[$];
    idle();
    for (int i = 1; i <= 4; i++) begin
      ld_issue = 1'b1; ld_addr = 5'(i);
      #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b want 1", i, ld_ready); end
      cycle();
    end
    ld_addr = 5'd5;
    #1;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready_full: got %b want 0", ld_ready); end
    cycle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL full_err: got %b want 1", err); end
    ld_issue = 1'b0;
    for (int c = 0; c < 8; c++) begin
      ld_ret_valid = (c < 4);
      ld_ret_data  = 32'h0000_0F00 + 32'(c);
      #1;
      checks++; if (ld_ready !== m_ready()) begin errors++; $display("FAIL full_ready_c%0d: got %b want %b", c, ld_ready, m_ready()); end
      cycle();
      if (D_En === 1'b1) begin
        got_a.push_back(D_Addr);
        got_d.push_back(D);
      end
    end
    checks++; if (got_a.size() != 4) begin errors++; $display("FAIL full_nwrites: got %0d want 4", got_a.size()); end
    for (int k = 0; k < got_a.size() && k < 4; k++) begin
      checks++; if (got_a[k] !== 5'(k + 1) || got_d[k] !== 32'h0000_0F00 + 32'(k)) begin
        errors++; $display("FAIL full_order%0d: got a=%0d d=%h want a=%0d d=%h", k, got_a[k], got_d[k], k + 1, 32'h0000_0F00 + 32'(k));
      end
    end
    idle();
  endtask

  task automatic test_spurious_reset();
    idle();
    rst = 1'b0;
    cycle();
    rst = 1'b1; ld_ret_valid = 1'b1; ld_ret_data = 32'h0000_0077;
    cycle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err: got %b want 1", err); end
    checks++; if (D_En !== 1'b0) begin errors++; $display("FAIL spur_den: got %b want 0", D_En); end
    ld_ret_valid = 1'b0; ld_issue = 1'b1; ld_addr = 5'd10;
    cycle();
    ld_addr = 5'd11;
    cycle();
    ld_issue = 1'b0; S_Addr = 5'd10; T_Addr = 5'd11;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall_pre: got %b want 1", stall); end
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b want 0", stall); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", ld_ready); end
    for (int c = 0; c < 5; c++) begin
      cycle();
      checks++; if (D_En !== 1'b0) begin errors++; $display("FAIL mid_den%0d: got %b want 0", c, D_En); end
    end
    idle();
  endtask

  task automatic test_random();
    idle();
    rst = 1'b0;
    cycle();
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 99) != 0);
      wb_valid     = ($urandom_range(0, 9) < 3);
      wb_addr      = 5'($urandom_range(0, 31));
      wb_data      = $urandom;
      ld_issue     = ($urandom_range(0, 9) < 4);
      ld_addr      = 5'($urandom_range(0, 7));
      ld_ret_valid = ($urandom_range(0, 9) < 4);
      ld_ret_data  = $urandom;
      S_Addr       = 5'($urandom_range(0, 7));
      T_Addr       = 5'($urandom_range(0, 7));
      dest_addr    = 5'($urandom_range(0, 7));
      #1;
      checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, m_stall()); end
      checks++; if (ld_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, ld_ready, m_ready()); end
      cycle();
      checks++; if (D_En !== exp_en || err !== exp_err) begin
        errors++; $display("FAIL rnd_ctl c%0d: got en=%b err=%b want en=%b err=%b", c, D_En, err, exp_en, exp_err);
      end
      checks++; if (D !== exp_d || D_Addr !== exp_a) begin
        errors++; $display("FAIL rnd_data c%0d: got a=%0d d=%h want a=%0d d=%h", c, D_Addr, D, exp_a, exp_d);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu();
    test_load_stall();
    test_collision();
    test_full();
    test_spurious_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
